// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial W-bit adder sequencer driving an external 4-bit adder
// Optional subtract mode: define SERIAL_ADD_SUB_EN to add the sub_i port.
module nibble_serial_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  input  logic         cin_i,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub_i,
`endif
  output logic [3:0]   add_a_o,
  output logic [3:0]   add_b_o,
  output logic         add_cin_o,
  input  logic [3:0]   add_s_i,
  input  logic         add_cout_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         ovf_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            cin_q;
  logic            carry_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;
`ifdef SERIAL_ADD_SUB_EN
  logic            sub_q;
`endif

  logic            run;
  logic            last;
  logic [3:0]      add_a_d;
  logic [3:0]      add_b_d;
  logic            add_cin_d;
  logic            ovf_d;
  logic            first_cin;

  assign run  = (state_q == S_RUN);
  assign last = (idx_q == IW'(NIBBLES - 1));

  // Subtraction is A + ~B + 1, so only the B nibble and the first carry differ.
`ifdef SERIAL_ADD_SUB_EN
  assign first_cin = sub_q ? 1'b1 : cin_q;
  assign add_b_d   = run ? (sub_q ? ~b_q[4*idx_q +: 4] : b_q[4*idx_q +: 4]) : 4'h0;
`else
  assign first_cin = cin_q;
  assign add_b_d   = run ? b_q[4*idx_q +: 4] : 4'h0;
`endif
  assign add_a_d   = run ? a_q[4*idx_q +: 4] : 4'h0;
  assign add_cin_d = run ? ((idx_q == '0) ? first_cin : carry_q) : 1'b0;

  // Carry into bit 3 of the top nibble is recovered from A^B^S, then compared with carry out.
  assign ovf_d = (add_a_d[3] ^ add_b_d[3] ^ add_s_i[3]) ^ add_cout_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            a_q     <= op_a_i;
            b_q     <= op_b_i;
            cin_q   <= cin_i;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub_i;
`endif
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          sum_q[4*idx_q +: 4] <= add_s_i;
          carry_q             <= add_cout_i;
          idx_q               <= idx_q + IW'(1);
          if (last) begin
            cout_q  <= add_cout_i;
            ovf_q   <= ovf_d;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign add_a_o   = add_a_d;
  assign add_b_o   = add_b_d;
  assign add_cin_o = add_cin_d;
  assign sum_o     = sum_q;
  assign cout_o    = cout_q;
  assign ovf_o     = ovf_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequencer that performs a NIBBLES×4-bit addition one nibble per clock through the team's existing 4-bit ripple carry adder. It sits directly upstream of that adder and also consumes its outputs. The block captures wide operands on a start strobe and drives the adder's A/B/carry-in inputs nibble by nibble. It collects each sum nibble and feeds the adder's carry-out back into the next nibble's carry-in. It then presents the full-width result with a one-cycle DONE pulse.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 1..16.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  request; sampled only in IDLE or DONE state.
- OP_A  in  W  operand A; captured when START is accepted.
- OP_B  in  W  operand B; captured when START is accepted.
- CIN  in  1  initial carry-in; captured when START is accepted.
- ADD_A  out  4  to adder A.
- ADD_B  out  4  to adder B.
- ADD_CIN  out  1  to adder Cin_in.
- ADD_S  in  4  from adder S.
- ADD_COUT  in  1  from adder Cout_out.
- SUM  out  W  result register.
- COUT  out  1  carry out of the MSB nibble.
- OVF  out  1  two's-complement signed overflow of the W-bit operation.
- BUSY  out  1  high in RUN state.
- DONE  out  1  one-cycle pulse; result valid.

## Operation
- State IDLE: BUSY=0, DONE=0. START=1 → capture OP_A/OP_B/CIN, clear nibble index idx to 0, go to RUN.
- State RUN: BUSY=1.
  - Drive ADD_A = A_reg[4*idx+3:4*idx] and ADD_B = B_reg nibble idx.
  - Drive ADD_CIN = CIN_reg when idx==0, otherwise carry_reg.
  - At each edge: SUM nibble idx ← ADD_S; carry_reg ← ADD_COUT; idx ← idx+1.
  - At the edge where idx==NIBBLES-1: COUT ← ADD_COUT; OVF ← (ADD_A[3]^ADD_B[3]^ADD_S[3]) ^ ADD_COUT; go to DONE.
- State DONE: DONE=1, BUSY=0 for exactly one cycle.
  - START=1 → accept a new operation immediately (back-to-back) and go to RUN.
  - Otherwise go to IDLE.
- START is ignored while in RUN; captured operands never change mid-operation.
- Outside RUN, ADD_A=0, ADD_B=0, ADD_CIN=0.
- SUM/COUT/OVF hold the last result until overwritten. SUM nibbles update progressively during RUN and are only valid when DONE=1 or afterward in IDLE.
- The adder is purely combinational. The ADD_* round trip must close within one cycle; the block adds no pipeline stage on that path.
- Reset, including mid-operation: state=IDLE, idx=0, all registers and outputs 0 (SUM=0, COUT=0, OVF=0, BUSY=0, DONE=0, ADD_*=0). An aborted operation produces no DONE.

## Timing
- START accepted at edge e0. BUSY is high from e0 through e(NIBBLES). DONE is high in the cycle after e(NIBBLES).
- Latency is NIBBLES+1 edges from START to DONE. Throughput is one operation per NIBBLES+1 cycles with back-to-back START.
- NIBBLES=1 degenerates to one RUN cycle followed by DONE.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Adds input port SUB (1 bit), captured with START.
  - With SUB=1, ADD_B is driven with the inverted B nibble, and the nibble-0 carry-in is 1 (CIN ignored). SUM = A−B mod 2^W, COUT=1 means no borrow, and OVF is signed subtraction overflow.
  - With SUB=0, behaviour is identical to the build without the macro.
- SERIAL_ADD_SUB_EN undefined: the SUB port is absent and the block is add-only.

## Test plan
- NIBBLES=4, 0x1234+0x4321, CIN=0 → SUM=0x5555, COUT=0, OVF=0; DONE exactly 5 edges after START; BUSY high for 4 cycles.
- 0xFFFF+0x0001, CIN=0 → SUM=0x0000, COUT=1; ADD_CIN observed 0,1,1,1 across the four RUN cycles.
- 0x7FFF+0x0001 → SUM=0x8000, OVF=1, COUT=0. Then 0x8000+0x8000 → SUM=0x0000, OVF=1, COUT=1.
- START pulsed during RUN with new operands → ignored; result matches the first operands. START held during the DONE cycle → a second operation starts with no IDLE cycle, and its DONE follows 5 edges later.
- RST_N asserted asynchronously in the middle of RUN (idx=2) → all outputs 0 immediately, no DONE; a subsequent START completes normally.
- SERIAL_ADD_SUB_EN build: SUB=1, 0x0005−0x0007 → SUM=0xFFFE, COUT=0. Then 0x8000−0x0001 → SUM=0x7FFF, OVF=1, COUT=1.
